wb_master_port: RTL

- Wishbone classic single-transfer initiator. Turns simple load/store requests from the core (or a debug loader) into bus cycles toward slaves such as the timer and memories.
- Handles byte lane selection, write data replication, and read data alignment with sign/zero extension.
- Reports misalignment, bus error and timeout as a single error response.
- One outstanding transaction at a time.

---
 rtl/wb_master_pkg.sv | 19 +
 rtl/wb_lane_align.sv | 42 ++++
 rtl/wb_master_port.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared encodings and sizing helpers for the Wishbone single-transfer initiator.
package wb_master_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } state_e;

  // Counter only has to reach cycles-1; keep at least one bit for cycles == 1.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Byte-lane steering: select generation, store data replication and load data
// alignment with sign/zero extension for a 32-bit bus.
module wb_lane_align
  import wb_master_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    sel_o   = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = '0;
    case (size_i)
      SZ_BYTE: begin
        sel_o   = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        sel_o   = 4'b0011 << offset_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        sel_o   = 4'b1111;
        rdata_o = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_master_port.sv
// Wishbone classic initiator: one outstanding load/store, with misalignment,
// bus error and timeout all folded into a single error response.
module wb_master_port
  import wb_master_pkg::*;
#(
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_SEL_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_unsigned_i,
  input  logic [WB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [WB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     wb_we_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
  output logic                     wb_stb_o,
  output logic                     wb_cyc_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i
);

  localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      size_q;
  logic [1:0]      offset_q;
  logic            unsigned_q;

  logic            accept;
  logic            req_legal;
  logic [1:0]      al_size;
  logic [1:0]      al_offset;
  logic            al_unsigned;
  logic [3:0]      al_sel;
  logic [31:0]     al_wdata;
  logic [31:0]     al_rdata;

  assign req_ready_o = (state_q == StIdle);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    case (req_size_i)
      SZ_BYTE: req_legal = 1'b1;
      SZ_HALF: req_legal = ~req_addr_i[0];
      SZ_WORD: req_legal = (req_addr_i[1:0] == 2'b00);
      default: req_legal = 1'b0;
    endcase
  end

  // The aligner serves the live request while idle and the latched one during the bus cycle.
  always_comb begin
    al_size     = req_ready_o ? req_size_i      : size_q;
    al_offset   = req_ready_o ? req_addr_i[1:0] : offset_q;
    al_unsigned = req_ready_o ? req_unsigned_i  : unsigned_q;
  end

  wb_lane_align u_lane_align (
    .size_i     (al_size),
    .offset_i   (al_offset),
    .unsigned_i (al_unsigned),
    .wdata_i    (req_wdata_i),
    .rdata_i    (wb_data_i),
    .sel_o      (al_sel),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      size_q      <= SZ_BYTE;
      offset_q    <= 2'b00;
      unsigned_q  <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= '0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            size_q     <= req_size_i;
            offset_q   <= req_addr_i[1:0];
            unsigned_q <= req_unsigned_i;
            cnt_q      <= '0;
            if (req_legal) begin
              wb_cyc_o  <= 1'b1;
              wb_stb_o  <= 1'b1;
              wb_we_o   <= req_we_i;
              wb_sel_o  <= al_sel;
              wb_addr_o <= {req_addr_i[WB_ADDR_WIDTH-1:2], 2'b00};
              wb_data_o <= al_wdata;
              state_q   <= StBus;
            end else begin
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
              state_q     <= StResp;
            end
          end
        end
        StBus: begin
          cnt_q <= cnt_q + 1'b1;
          if (wb_err_i || wb_ack_i || (cnt_q == CntLast)) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= '0;
            cnt_q    <= '0;
            state_q  <= StResp;
            if (!wb_err_i && wb_ack_i) begin
              rsp_err_o   <= 1'b0;
              rsp_rdata_o <= wb_we_o ? '0 : al_rdata;
            end else begin
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end
          end
        end
        StResp: begin
          rsp_valid_o <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
